fsk_demod: RTL

Receive-side companion to the FSK modulator in the DDS datapath. Takes the 16-bit FSK sample stream, squares it with a hysteresis comparator, and counts rising zero crossings over each symbol window. At the end of each window it decides whether the symbol was the carrier tone (bit 1) or the modulated tone (bit 0). Bits are assembled MSB-first into 16-bit code words, matching the modulator's bit order of 15 down to 0.

---
 rtl/fsk_demod_if.sv | 22 ++
 rtl/fsk_demod.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fsk_demod_if.sv
// Sample, control and decoded-output bundle of the FSK demodulator.
// The master side drives the samples and controls; the slave side returns bits and words.
interface fsk_demod_if;
    logic        en;
    logic        resync;
    logic [15:0] fsk_sig;
    logic        bit_out;
    logic        bit_valid;
    logic [15:0] code_out;
    logic        code_valid;
    logic        locked;

    modport master (
        output en, resync, fsk_sig,
        input  bit_out, bit_valid, code_out, code_valid, locked
    );

    modport slave (
        input  en, resync, fsk_sig,
        output bit_out, bit_valid, code_out, code_valid, locked
    );
endinterface

// File: rtl/fsk_demod.sv
// FSK demodulator: hysteresis comparator, rising-edge count per symbol window,
// threshold decision, and MSB-first assembly of 16-bit code words.
//
// state | meaning
// IDLE  | disabled, counters cleared, waiting for en
// ACQ   | enabled, waiting for first rising edge to align the symbol window
// RUN   | windows running, one decided bit per SYM_LEN clocks
module fsk_demod #(
    parameter int          SYM_LEN  = 9766,
    parameter logic [15:0] MID      = 16'd32768,
    parameter logic [15:0] HYST     = 16'd64,
    parameter logic [15:0] EDGE_THR = 16'd8
) (
    input  logic        clk_100M,
    input  logic        rst_n,
    fsk_demod_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACQ, RUN} state_t;

    localparam int              TW     = $clog2(SYM_LEN + 1);
    localparam logic [TW-1:0]   T_END  = TW'(SYM_LEN - 1);
    localparam logic [15:0]     HI_THR = MID + HYST;
    localparam logic [15:0]     LO_THR = MID - HYST;

    state_t        state, state_nxt;
    logic [15:0]   s_q;
    logic          hi, hi_d, rise;
    logic [TW-1:0] timer;
    logic [15:0]   edge_cnt, cnt_fin;
    logic [3:0]    bit_idx;
    logic [15:0]   shreg, word_fin;
    logic          win_end, bit_dec, locked;
    logic          bit_out, bit_valid, code_valid;
    logic [15:0]   code_out;

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            s_q  <= '0;
            hi   <= 1'b0;
            hi_d <= 1'b0;
        end else begin
            s_q  <= bus.fsk_sig;
            hi_d <= hi;
            if (s_q >= HI_THR)
                hi <= 1'b1;
            else if (s_q < LO_THR)
                hi <= 1'b0;
        end
    end

    assign rise = hi & ~hi_d;

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!bus.en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ACQ;
                ACQ:     if (!bus.resync && rise) state_nxt = RUN;
                RUN:     if (bus.resync) state_nxt = ACQ;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        locked = 1'b0;
        if (state == RUN)
            locked = 1'b1;
    end

    // The window-end decision must see an edge landing in that same cycle.
    always_comb begin
        cnt_fin = edge_cnt;
        if (rise && edge_cnt != 16'hFFFF)
            cnt_fin = edge_cnt + 16'd1;
        win_end  = (timer == T_END);
        bit_dec  = (cnt_fin >= EDGE_THR);
        word_fin = shreg;
        word_fin[bit_idx] = bit_dec;
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            timer      <= '0;
            edge_cnt   <= '0;
            bit_idx    <= 4'd15;
            shreg      <= '0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            code_out   <= '0;
            code_valid <= 1'b0;
        end else begin
            bit_valid  <= 1'b0;
            code_valid <= 1'b0;
            if (!bus.en || state == IDLE || bus.resync) begin
                timer    <= '0;
                edge_cnt <= '0;
                bit_idx  <= 4'd15;
                shreg    <= '0;
            end else if (state == ACQ) begin
                if (rise) begin
                    timer    <= TW'(1);
                    edge_cnt <= 16'd1;
                    bit_idx  <= 4'd15;
                end
            end else if (win_end) begin
                timer     <= '0;
                edge_cnt  <= '0;
                shreg     <= word_fin;
                bit_out   <= bit_dec;
                bit_valid <= 1'b1;
                bit_idx   <= bit_idx - 4'd1;
                if (bit_idx == 4'd0) begin
                    code_out   <= word_fin;
                    code_valid <= 1'b1;
                end
            end else begin
                timer    <= timer + TW'(1);
                edge_cnt <= cnt_fin;
            end
        end
    end

    assign bus.locked     = locked;
    assign bus.bit_out    = bit_out;
    assign bus.bit_valid  = bit_valid;
    assign bus.code_out   = code_out;
    assign bus.code_valid = code_valid;
endmodule
